// File: rtl/alloc_encoder_32_if.sv
// Handshake bundle between the free-entry allocator and its consumer/releaser.
// The master side is the allocator; the slave side is the rename/issue logic.
interface alloc_encoder_32_if #(
  parameter int N = 32,
  parameter int W = 5
);
  logic         alloc_valid;
  logic [W-1:0] alloc_idx;
  logic         alloc_ready;
  logic         rel_valid;
  logic [W-1:0] rel_idx;
  logic         flush;
  logic [W:0]   free_cnt;
  logic         dbl_free_err;

  modport master (
    output alloc_valid, alloc_idx, free_cnt, dbl_free_err,
    input  alloc_ready, rel_valid, rel_idx, flush
  );

  modport slave (
    input  alloc_valid, alloc_idx, free_cnt, dbl_free_err,
    output alloc_ready, rel_valid, rel_idx, flush
  );
endinterface

// File: rtl/alloc_encoder_32.sv
// 32-entry free-list allocator: presents the lowest free index, takes one
// allocation and one binary-indexed release per cycle, flags double frees.
module alloc_encoder_32 #(
  parameter int N = 32,
  parameter int W = 5
) (
  input  logic              clk,
  input  logic              rst,
  alloc_encoder_32_if.master bus
);

  logic [N-1:0] free_vec;
  logic [W:0]   cnt_q;
  logic         err_q;

  logic [W-1:0] lo_idx;
  logic         any_free;
  logic         alloc_fire;
  logic         rel_hit_free;
  logic         rel_ok;
  logic [N-1:0] alloc_mask;
  logic [N-1:0] rel_mask;

  function automatic logic [W-1:0] prio_enc(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) idx = W'(i);
    end
    return idx;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [W-1:0] idx);
    return {{(N-1){1'b0}}, 1'b1} << idx;
  endfunction

  always_comb begin
    any_free     = |free_vec;
    lo_idx       = prio_enc(free_vec);
    alloc_fire   = any_free & bus.alloc_ready;
    alloc_mask   = alloc_fire ? onehot(lo_idx) : '0;
    // rel_idx only reaches the mask behind rel_valid, so an X index cannot leak in
    rel_mask     = bus.rel_valid ? onehot(bus.rel_idx) : '0;
    rel_hit_free = |(rel_mask & free_vec);
    rel_ok       = bus.rel_valid & ~rel_hit_free;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      free_vec <= '1;
      cnt_q    <= (W+1)'(N);
      err_q    <= 1'b0;
    end else if (bus.flush) begin
      free_vec <= '1;
      cnt_q    <= (W+1)'(N);
    end else begin
      // A valid release never targets a free entry, so it cannot collide with the allocated one
      free_vec <= (free_vec & ~alloc_mask) | (rel_ok ? rel_mask : '0);
      case ({rel_ok, alloc_fire})
        2'b10:   cnt_q <= cnt_q + (W+1)'(1);
        2'b01:   cnt_q <= cnt_q - (W+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (bus.rel_valid && rel_hit_free) err_q <= 1'b1;
    end
  end

  assign bus.alloc_valid  = any_free;
  assign bus.alloc_idx    = lo_idx;
  assign bus.free_cnt     = cnt_q;
  assign bus.dbl_free_err = err_q;

endmodule

// File: doc/alloc_encoder_32.md
# alloc_encoder_32

- Allocator for a 32-entry resource pool, such as physical registers or ROB/buffer slots.
- Holds a free bitmap and priority-encodes it to present the lowest-numbered free index to a consumer over a valid/ready handshake.
- Accepts one release per cycle as a binary index, decoded internally to a one-hot clear mask.
- Sits next to the rename/issue logic. It is the encoding counterpart of the 5→32 one-hot decoders used in the datapath: one-hot state in, binary index out.

## Interface
Parameters:
- N, 32, number of entries (fixed at 32 for this revision)
- W, 5, index width (log2 N)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- alloc_valid  out  1  at least one entry is free
- alloc_idx  out  W  lowest-numbered free index; 0 when alloc_valid=0
- alloc_ready  in  1  consumer takes alloc_idx this cycle
- rel_valid  in  1  release request
- rel_idx  in  W  index being released
- flush  in  1  return every entry to the free state
- free_cnt  out  W+1  number of free entries, 0..32
- dbl_free_err  out  1  sticky: a release targeted an already-free entry

## Operation
- State:
  - free_vec[N-1:0]: 1 = free.
  - free_cnt register.
  - dbl_free_err register.
- Reset (rst=1 at a clock edge):
  - free_vec = all ones, free_cnt = 32, dbl_free_err = 0.
  - Resulting outputs: alloc_valid=1, alloc_idx=0.
- Outputs:
  - alloc_valid = |free_vec.
  - alloc_idx = index of the lowest set bit of free_vec. It is a combinational priority encode of registered state with no input-to-output path.
- Allocation fires when alloc_valid && alloc_ready.
  - Clear free_vec[alloc_idx].
  - alloc_ready while alloc_valid=0 has no effect.
- Release fires when rel_valid.
  - If free_vec[rel_idx]=0: set the bit.
  - If free_vec[rel_idx]=1 (double free): free_vec is unchanged and dbl_free_err is set to 1. It stays 1 until reset; flush does not clear it.
  - A double free is ignored even when it matches the currently presented alloc_idx in the same cycle that allocation fires. Allocation still clears the bit, and the error is still flagged.
- free_cnt next value:
  - +1 for a valid (non-double) release only.
  - −1 for a fired allocation only.
  - Unchanged when both occur, or neither.
  - Must always equal popcount(free_vec). It never wraps below 0 or above 32.
- Simultaneous allocation and valid release of different indices: both take effect in the same edge.
- Flush has the highest priority after rst.
  - free_vec = all ones, free_cnt = 32.
  - Any same-cycle allocation or release is discarded.
  - The consumer must treat an alloc handshake in a flush cycle as void.
- Reset mid-operation discards all state with no draining. The first post-reset cycle presents idx 0.
- rel_idx is ignored when rel_valid=0. No X propagation into free_vec.

## Timing
- All updates take effect at the next rising edge. alloc_idx and alloc_valid reflect the new free_vec in the following cycle.
- Allocation throughput: one per cycle. With alloc_ready held high, indices come out in ascending order of the free bits, one per cycle.
- Release-to-reuse latency: 1 cycle. An index released at edge k can be presented from cycle k+1 if it is the lowest free entry.
- Full pool: when all 32 entries are allocated, alloc_valid=0 and alloc_idx=0 in the cycle after the 32nd handshake.
- Release and allocation in the same cycle when the pool has exactly one free entry:
  - The presented entry is allocated and the released entry becomes free.
  - Next cycle: alloc_valid=1, free_cnt=1.
- Reset to first valid allocation: 0 cycles after reset deasserts.

## Test plan
- Reset, then idle → alloc_valid=1, alloc_idx=0, free_cnt=32, dbl_free_err=0.
- alloc_ready held high for 33 cycles → alloc_idx sequence 0,1,…,31; then alloc_valid=0, alloc_idx=0, free_cnt=0. The 33rd ready has no effect.
- From full, release 7, then release 3 one cycle later:
  - Cycle after the first release: alloc_idx=7, free_cnt=1.
  - Cycle after the second release: alloc_idx=3, free_cnt=2.
- After allocating 0..4, assert alloc_ready and rel_valid (rel_idx=2) in the same cycle → idx 5 taken, free_cnt stays 27. Next alloc_idx=2.
- Release idx 20 while it is free → free_vec and free_cnt unchanged, dbl_free_err=1. Flush → dbl_free_err remains 1; only rst clears it.
- After 10 allocations, assert flush together with alloc_ready and rel_valid (rel_idx=4) → next cycle free_cnt=32, alloc_idx=0. Repeat with rst asserted mid-sequence → identical post-reset values.
